// File: rtl/poly_synth.sv
// poly_synth: polyphonic triangle-wave tone generator with a time-multiplexed averaging mixer.
// Define POLY_SYNTH_ENV_EN to add the per-voice attack/sustain/release envelope.
module poly_synth #(
    parameter int VOICES     = 8,
    parameter int OUT_W      = 8,
    parameter int PHASE_W    = 16,
    parameter int SAMPLE_DIV = 256,
    parameter int ENV_STEP   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [VOICES-1:0]            keys,
    input  logic [VOICES*PHASE_W-1:0]    tune_inc,
    output logic [OUT_W-1:0]             sound,
    output logic                         sound_valid,
    output logic [$clog2(VOICES+1)-1:0]  active_cnt
);
    localparam int ACC_W = OUT_W + $clog2(VOICES);
    localparam int CNT_W = $clog2(VOICES + 1);
    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int IDX_W = $clog2(VOICES + ACC_W);
    localparam int VI_W  = $clog2(VOICES);

    if (ENV_STEP < 1 || ENV_STEP >= 2**OUT_W || SAMPLE_DIV < VOICES + ACC_W + 3) begin : g_param_check
        $error("poly_synth: invalid parameter combination");
    end

    logic [DIV_W-1:0]   div_cnt;
    logic               tick;
    logic [VOICES-1:0]  active_nxt;
    logic [CNT_W-1:0]   active_sum;
    logic [PHASE_W-1:0] phase [VOICES];

    assign tick = (div_cnt == DIV_W'(SAMPLE_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + DIV_W'(1);
    end

`ifdef POLY_SYNTH_ENV_EN
    typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} env_state_t;
    localparam logic [OUT_W-1:0] ENV_MAX = '1;
    localparam logic [OUT_W-1:0] STEP    = OUT_W'(ENV_STEP);

    env_state_t       state     [VOICES];
    env_state_t       state_nxt [VOICES];
    logic [OUT_W-1:0] env       [VOICES];
    logic [OUT_W-1:0] env_nxt   [VOICES];
    logic [OUT_W-1:0] env_up    [VOICES];
    logic [OUT_W-1:0] env_dn    [VOICES];
    logic [OUT_W:0]   env_sum   [VOICES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < VOICES; i++) begin
                state[i] <= IDLE;
                env[i]   <= '0;
            end
        end else if (tick) begin
            for (int unsigned i = 0; i < VOICES; i++) begin
                state[i] <= state_nxt[i];
                env[i]   <= env_nxt[i];
            end
        end
    end

    // A held key always climbs from the current level; a released key always decays,
    // so IDLE->ATTACK and RELEASE->ATTACK collapse into the same transition.
    always_comb begin
        for (int unsigned i = 0; i < VOICES; i++) begin
            env_sum[i] = {1'b0, env[i]} + {1'b0, STEP};
            env_up[i]  = env_sum[i][OUT_W] ? ENV_MAX : env_sum[i][OUT_W-1:0];
            env_dn[i]  = (env[i] < STEP) ? '0 : env[i] - STEP;
            if (keys[i])
                state_nxt[i] = (env_up[i] == ENV_MAX) ? SUSTAIN : ATTACK;
            else
                state_nxt[i] = (env_dn[i] == '0) ? IDLE : RELEASE;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < VOICES; i++) begin
            case (state_nxt[i])
                ATTACK, SUSTAIN: env_nxt[i] = env_up[i];
                RELEASE:         env_nxt[i] = env_dn[i];
                default:         env_nxt[i] = '0;
            endcase
            active_nxt[i] = (state_nxt[i] != IDLE);
        end
    end
`else
    assign active_nxt = keys;
`endif

    always_comb begin
        active_sum = '0;
        for (int unsigned i = 0; i < VOICES; i++)
            active_sum = active_sum + CNT_W'(active_nxt[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < VOICES; i++) phase[i] <= '0;
            active_cnt <= '0;
        end else if (tick) begin
            for (int unsigned i = 0; i < VOICES; i++)
                phase[i] <= active_nxt[i] ? phase[i] + tune_inc[i*PHASE_W +: PHASE_W] : '0;
            active_cnt <= active_sum;
        end
    end

    typedef enum logic [1:0] {M_IDLE, M_ACC, M_DIV} mix_state_t;
    mix_state_t       mix_state, mix_nxt;
    logic [IDX_W-1:0] idx;
    logic [VI_W-1:0]  voice_idx;
    logic [ACC_W-1:0] acc, q_nxt;
    logic [CNT_W-1:0] rem;
    logic [CNT_W:0]   rem_sh;
    logic             rem_ge, acc_last, div_last, acc_en, div_en;
    logic [OUT_W-1:0] tri_t, wave_sel, v_sel;

    assign voice_idx = idx[VI_W-1:0];
    assign tri_t     = phase[voice_idx][PHASE_W-2 -: OUT_W];
    assign wave_sel  = phase[voice_idx][PHASE_W-1] ? ~tri_t : tri_t;
`ifdef POLY_SYNTH_ENV_EN
    assign v_sel = OUT_W'(((2*OUT_W)'(wave_sel) * (2*OUT_W)'(env[voice_idx])) >> OUT_W);
`else
    assign v_sel = wave_sel;
`endif

    assign acc_last = (idx == IDX_W'(VOICES - 1));
    assign div_last = (idx == IDX_W'(ACC_W - 1));

    // acc doubles as the dividend/quotient shift register during the divide phase
    assign rem_sh = {rem, acc[ACC_W-1]};
    assign rem_ge = (rem_sh >= {1'b0, active_cnt});
    assign q_nxt  = {acc[ACC_W-2:0], rem_ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mix_state <= M_IDLE;
        else        mix_state <= mix_nxt;
    end

    always_comb begin
        mix_nxt = mix_state;
        case (mix_state)
            M_IDLE:  if (tick)     mix_nxt = M_ACC;
            M_ACC:   if (acc_last) mix_nxt = M_DIV;
            M_DIV:   if (div_last) mix_nxt = M_IDLE;
            default:               mix_nxt = M_IDLE;
        endcase
    end

    always_comb begin
        acc_en = (mix_state == M_ACC);
        div_en = (mix_state == M_DIV);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            acc         <= '0;
            rem         <= '0;
            sound       <= '0;
            sound_valid <= 1'b0;
        end else begin
            sound_valid <= 1'b0;
            if (mix_state == M_IDLE) begin
                idx <= '0;
                acc <= '0;
                rem <= '0;
            end
            if (acc_en) begin
                acc <= acc + ACC_W'(v_sel);
                idx <= acc_last ? '0 : idx + IDX_W'(1);
            end
            if (div_en) begin
                acc <= q_nxt;
                rem <= CNT_W'(rem_ge ? rem_sh - {1'b0, active_cnt} : rem_sh);
                idx <= idx + IDX_W'(1);
                if (div_last) begin
                    sound       <= (active_cnt == '0) ? '0 : q_nxt[OUT_W-1:0];
                    sound_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/poly_synth.md
# poly_synth

Parametrised polyphonic tone generator: the next generation of the 8-key piano voice block. Each of VOICES keys drives its own phase-accumulator oscillator with a triangle waveform and a per-voice attack/sustain/release envelope. A time-multiplexed mixer sums the voices and divides by the number of sounding voices to produce one OUT_W-bit sample per sample period for the DAC/PWM stage.

## Interface
- VOICES, 8: number of keys/voices (2..16).
- OUT_W, 8: sample and voice width.
- PHASE_W, 16: phase accumulator width (≥ OUT_W+2).
- SAMPLE_DIV, 256: clk cycles per sample; must be ≥ VOICES+ACC_W+3, where ACC_W = OUT_W+clog2(VOICES).
- ENV_STEP, 4: envelope increment/decrement per sample.
- Clock is `clk`; reset is `rst_n`, asynchronous, active-low; one clock domain.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- keys  in  VOICES  key i held = 1; sampled only at tick.
- tune_inc  in  VOICES*PHASE_W  phase increment of voice i in bits [i*PHASE_W +: PHASE_W]; sampled at tick.
- sound  out  OUT_W  mixed sample; reset 0.
- sound_valid  out  1  one-cycle pulse when sound updates; reset 0.
- active_cnt  out  clog2(VOICES+1)  number of non-IDLE voices; reset 0.

## Operation
- Sample counter 0..SAMPLE_DIV-1; tick = cycle where counter = SAMPLE_DIV-1; counter wraps to 0.
- At tick, per voice, in parallel: key latched; envelope FSM advances; phase += tune_inc (mod 2^PHASE_W) if the voice is non-IDLE after the update; otherwise phase forced to 0 (notes start at phase 0).
- Envelope FSM per voice, level env (OUT_W bits):
  - IDLE (env=0): key=1 → ATTACK.
  - ATTACK: env += ENV_STEP, saturating at 2^OUT_W-1; on reaching max → SUSTAIN; key=0 → RELEASE.
  - SUSTAIN: env = max; key=0 → RELEASE.
  - RELEASE: env -= ENV_STEP, saturating at 0; on reaching 0 → IDLE; key=1 → ATTACK from the current level (no reset to 0).
- Waveform: t = phase[PHASE_W-2 -: OUT_W]; wave = phase[PHASE_W-1] ? ~t : t (unsigned triangle, 0..2^OUT_W-1).
- Voice sample v = (wave*env) >> OUT_W, truncating.
- Mixer: accumulate v of voices 0..VOICES-1, one per cycle, into ACC_W bits (cannot overflow). Then restoring divide acc / active_cnt over ACC_W cycles, floor. Quotient truncated to OUT_W bits; it is ≤ max by construction. active_cnt = 0 → sound = 0.
- active_cnt updates at tick, counting voices non-IDLE after the FSM update.

## Timing
- Tick at cycle T. Accumulate voice i at cycle T+1+i. Divide in T+VOICES+1 .. T+VOICES+ACC_W. sound registered and sound_valid = 1 in cycle T+VOICES+ACC_W+1 (defaults: T+20).
- sound holds its value between updates. Exactly one sound_valid pulse per sample period.
- keys/tune_inc changes between ticks have no effect until the next tick; the sweep uses values latched at tick.
- Reset asserted anywhere, including mid-sweep: all outputs, phases, envelopes (IDLE, 0), counter and mixer state clear immediately. First tick occurs SAMPLE_DIV cycles after release.

## Configuration
- `POLY_SYNTH_ENV_EN` defined: envelope FSM as above.
- Not defined: no FSM or multiplier. A voice is active iff its latched key = 1; v = wave; env logic absent. active_cnt = number of held keys. Phase is forced to 0 when the key is released.

## Test plan
- Reset mid-sweep (keys=8'hFF), rst_n low 3 cycles → sound=0, sound_valid=0, active_cnt=0 at once; first sound_valid 256+20 cycles after release.
- keys=0 → sound_valid every 256 cycles, sound=0, active_cnt=0.
- ENV off, keys=8'h01, inc0=16'h0400 → after 8 ticks phase=16'h2000, sound=8'h40; after 31 ticks phase=16'h7C00, sound=8'hF8; phase wraps to 0 after 64 ticks.
- ENV off, keys=8'h03, inc0=inc1=16'h0400 → sound identical to the single-key case, active_cnt=2.
- ENV on, keys=8'h01 → env reaches 255 at tick 64 (SUSTAIN). Release → env reaches 0 at tick 64 of release, active_cnt 1→0, sound=0.
- ENV on, re-press after 10 release ticks (env=215) → ATTACK continues from 215 and reaches 255 after 10 ticks.
